codec_frame_tx: RTL and testbench
=================================

Name: codec_frame_tx

Overview:
- Codec-side serializer: the producer of `new_frame` and the consumer of the conditioned 16-bit sample.
- Generates the bit clock and word-select clock, pulses `new_frame` once per stereo frame, captures `valid_sample` and shifts it out MSB-first in I2S format.
- The same sample is sent on the left and right channels.
- Sits between `codec_conditioner` and the external DAC pins, replacing the vendor AC97 interface in simulation and in board builds.

Parameters:
- CLK_DIV, 4: clk cycles per bclk half-period; legal values are 2 or more.
- SAMPLE_WIDTH, 16: bits per audio sample.
- SLOT_WIDTH, 32: bclk periods per channel slot. A frame is 2*SLOT_WIDTH bits. SLOT_WIDTH must be at least SAMPLE_WIDTH+1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run the serial link; when low, the link idles at a frame boundary
- valid_sample  in  SAMPLE_WIDTH  sample from codec_conditioner, two's complement
- new_frame  out  1  one-clk pulse at the start of each frame
- bclk  out  1  serial bit clock; data changes on its falling edge
- lrclk  out  1  word select: 0 = left slot, 1 = right slot
- sdata  out  1  serial data
- busy  out  1  high while a frame is in progress

Behaviour:
- Reset values: all outputs 0; div_cnt=0, bit_cnt=0, shift register=0, state IDLE.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while state is RUN.
  - At CLK_DIV-1 it wraps to 0 and bclk toggles.
  - A "fall event" is the cycle in which bclk goes 1 to 0.
- States:
  - IDLE to RUN when enable=1 (checked every clk). Entering RUN sets bit_cnt=0, pulses new_frame in that same cycle, and sets busy=1.
  - RUN to IDLE on the fall event that ends bit 2*SLOT_WIDTH-1, only if enable=0. At that point bclk=0, lrclk=0, sdata=0, busy=0.
  - Deasserting enable mid-frame always completes the current frame.
- Bit counter:
  - Increments on every fall event and wraps from 2*SLOT_WIDTH-1 to 0.
  - On the wrap with enable=1, new_frame pulses for exactly 1 clk in that same cycle.
- lrclk: 0 for bit_cnt 0..SLOT_WIDTH-1; 1 for SLOT_WIDTH..2*SLOT_WIDTH-1.
- Sample capture:
  - On the fall event entering bit_cnt=1, valid_sample is loaded into the hold and shift registers.
  - This is 2*CLK_DIV clk after new_frame, so codec_conditioner has at least 4 cycles to update.
- Serial data (I2S one-bit delay):
  - Left slot: bit_cnt 1..SAMPLE_WIDTH carries the sample MSB-first.
  - Right slot: bit_cnt SLOT_WIDTH+1..SLOT_WIDTH+SAMPLE_WIDTH carries the held sample MSB-first. It is reloaded from the hold register on the fall event entering SLOT_WIDTH+1.
  - All other bits are 0.
- sdata is registered and only changes on fall events.
- If valid_sample changes between captures, it has no effect until the next capture.
- Reset asserted mid-frame: outputs return to their reset values immediately (asynchronous). No partial new_frame pulse is produced.

Optional Feature:
- Macro: CODEC_FRAME_TX_COUNT_EN.
- Defined:
  - Adds output frame_count [15:0], reset 0.
  - Increments by 1 in the same cycle as each new_frame pulse and wraps 16'hFFFF to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package `codec_pkg` holds SAMPLE_WIDTH_DEF=16, SLOT_WIDTH_DEF=32 and the state encoding (IDLE=1'b0, RUN=1'b1).
- One sub-module, `bclk_divider`:
  - Inputs: clk, reset, run.
  - Outputs: bclk, fall_evt.
  - Parameterized by CLK_DIV.
- Bit counter, capture and shift logic stay in the top module.

Test Plan (CLK_DIV=2, SLOT_WIDTH=32, SAMPLE_WIDTH=16, so 256 clk per frame):
- Reset held, enable=1 -> bclk, lrclk, sdata, busy and new_frame all 0. Release -> new_frame pulses the next clk. busy=1.
- Steady run, 4 frames -> new_frame pulses exactly 256 clk apart, each 1 clk wide. lrclk high for 128 clk per frame.
- valid_sample=16'hA5C3 updated 1 clk after new_frame -> sdata bits 1..16 and 33..48 sample 1010_0101_1100_0011 on bclk rising edges. Bits 0, 17..32 and 49..63 are 0.
- valid_sample changed to 16'h0001 at bit_cnt=20 -> right slot still carries the captured value. The next frame carries 16'h0001.
- enable dropped at bit_cnt=10 -> the frame completes to bit 63. Then busy=0, bclk=0, and no further new_frame. Re-enable -> new_frame the next clk.
- reset pulsed for 1 clk at bit_cnt=40 -> all outputs 0 that cycle. With enable=1, the link restarts with new_frame one clk after release. With CODEC_FRAME_TX_COUNT_EN, frame_count=0 then 1.

Source files
------------

// File: rtl/codec_pkg.sv
// Shared definitions for the codec serial transmit path: default sample and
// slot widths and the link state encoding.
package codec_pkg;

  localparam int unsigned SAMPLE_WIDTH_DEF = 16;
  localparam int unsigned SLOT_WIDTH_DEF   = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/codec_frame_tx_bclk_divider.sv
// Bit-clock generator: toggles bclk every CLK_DIV clk while run is high and
// flags the clk in which bclk falls. Parks at bclk=0 when run is low.
module bclk_divider #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bclk,
  output logic fall_evt
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          div_wrap;

  assign div_wrap = (div_cnt == DW'(CLK_DIV - 1));
  assign fall_evt = run & bclk & div_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/codec_frame_tx.sv
// I2S frame serializer: sends one captured sample MSB-first on both channel
// slots. Optional frame counter output enabled by CODEC_FRAME_TX_COUNT_EN.
module codec_frame_tx
  import codec_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int unsigned SLOT_WIDTH   = SLOT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] valid_sample,
  output logic                    new_frame,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    busy
`ifdef CODEC_FRAME_TX_COUNT_EN
  ,
  output logic [15:0]             frame_count
`endif
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned BW         = $clog2(FRAME_BITS);
  localparam int unsigned LAST_BIT   = FRAME_BITS - 1;

  state_t                  state, state_nxt;
  logic                    frame_start, frame_stop;
  logic                    fall_evt;
  logic [BW-1:0]           bit_cnt, bit_nxt;
  logic                    data_slot;
  logic [SAMPLE_WIDTH-1:0] hold, shift_reg;

  bclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk     (clk),
    .reset   (reset),
    .run     (state == RUN),
    .bclk    (bclk),
    .fall_evt(fall_evt)
  );

  assign bit_nxt   = (bit_cnt == BW'(LAST_BIT)) ? '0 : bit_cnt + BW'(1);
  // Bits that shift out held sample data after the per-slot load bit.
  assign data_slot = ((bit_nxt != '0) && (bit_nxt <= BW'(SAMPLE_WIDTH))) ||
                     ((bit_nxt > BW'(SLOT_WIDTH)) &&
                      (bit_nxt <= BW'(SLOT_WIDTH + SAMPLE_WIDTH)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_stop  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt   = RUN;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        // enable is only sampled at the frame boundary so frames never truncate
        if (fall_evt && (bit_cnt == BW'(LAST_BIT))) begin
          if (enable) begin
            frame_start = 1'b1;
          end else begin
            state_nxt  = IDLE;
            frame_stop = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      new_frame <= 1'b0;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      hold      <= '0;
      shift_reg <= '0;
    end else begin
      new_frame <= frame_start;
      if (frame_start)     busy <= 1'b1;
      else if (frame_stop) busy <= 1'b0;
      if (fall_evt) begin
        bit_cnt <= bit_nxt;
        lrclk   <= (bit_nxt >= BW'(SLOT_WIDTH));
        if (bit_nxt == BW'(1)) begin
          hold      <= valid_sample;
          shift_reg <= valid_sample << 1;
          sdata     <= valid_sample[SAMPLE_WIDTH-1];
        end else if (bit_nxt == BW'(SLOT_WIDTH + 1)) begin
          shift_reg <= hold << 1;
          sdata     <= hold[SAMPLE_WIDTH-1];
        end else if (data_slot) begin
          shift_reg <= shift_reg << 1;
          sdata     <= shift_reg[SAMPLE_WIDTH-1];
        end else begin
          sdata     <= 1'b0;
        end
      end
    end
  end

`ifdef CODEC_FRAME_TX_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            frame_count <= '0;
    else if (frame_start) frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_codec_frame_tx.sv
// Scoreboard bench for codec_frame_tx: expected frames are queued by the
// stimulus and checked by a monitor that reassembles bits on bclk rising edges.
module tb_codec_frame_tx;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned SW      = 16;
  localparam int unsigned SLOT    = 32;
  localparam logic [63:0] LR_EXP  = 64'hFFFF_FFFF_0000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [SW-1:0] valid_sample;
  logic          new_frame, bclk, lrclk, sdata, busy;
`ifdef CODEC_FRAME_TX_COUNT_EN
  logic [15:0]   frame_count;
`endif

  codec_frame_tx #(.CLK_DIV(CLK_DIV), .SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLOT)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .valid_sample(valid_sample),
    .new_frame   (new_frame),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .busy        (busy)
`ifdef CODEC_FRAME_TX_COUNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] sd;
    logic [31:0] gap;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   nf_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 64'(act), 64'(exp));
  endtask

  // Bit k of the result is the sdata value carried by frame bit k.
  function automatic logic [63:0] make_frame(input logic [15:0] s);
    logic [63:0] f;
    f = '0;
    for (int k = 1; k <= 16; k++) begin
      f[k]      = s[16-k];
      f[32 + k] = s[16-k];
    end
    return f;
  endfunction

  task automatic wait_nf(output int n);
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 600) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (new_frame) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL nf_timeout: no new_frame within %0d clk", n);
    end
  endtask

  task automatic frame(input logic [15:0] s, input int gap, input bit push, output int n);
    exp_t e;
    wait_nf(n);
    if (push) begin
      e.sd  = make_frame(s);
      e.gap = 32'(gap);
      sb.push_back(e);
    end
    @(posedge clk);
    #1 valid_sample = s;
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_bclk"},  bclk,      1'b0);
    chk1({tag, "_lrclk"}, lrclk,     1'b0);
    chk1({tag, "_sdata"}, sdata,     1'b0);
    chk1({tag, "_busy"},  busy,      1'b0);
    chk1({tag, "_nf"},    new_frame, 1'b0);
  endtask

  // Monitor: reassemble each frame and compare against the scoreboard head.
  int          mon_cyc = 0, last_nf = 0, nf_at = 0, cur_gap = 0, idx = 0;
  bit          have_prev = 1'b0, collecting = 1'b0, bclk_q = 1'b0, nf_q = 1'b0;
  logic [63:0] word, lrw;
  exp_t        me;

  always @(negedge clk) begin
    mon_cyc++;
    if (reset) begin
      collecting = 1'b0;
      have_prev  = 1'b0;
      bclk_q     = 1'b0;
      nf_q       = 1'b0;
    end else begin
      if (nf_q) chk1("nf_width", new_frame, 1'b0);
      if (new_frame && !nf_q) begin
        cur_gap    = have_prev ? (mon_cyc - last_nf) : 0;
        last_nf    = mon_cyc;
        nf_at      = mon_cyc;
        have_prev  = 1'b1;
        collecting = 1'b1;
        idx        = 0;
        word       = '0;
        lrw        = '0;
        nf_seen++;
      end
      if (collecting && bclk && !bclk_q) begin
        word[idx] = sdata;
        lrw[idx]  = lrclk;
        idx++;
        if (idx == 64) begin
          collecting = 1'b0;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected: got %h expected none", word);
          end else begin
            me = sb.pop_front();
            chk("sdata_frame", word, me.sd);
            chk("lrclk_frame", lrw, LR_EXP);
            chk("bit63_latency", 64'(mon_cyc - nf_at), 64'd254);
            if (me.gap != 0) chk("nf_gap", 64'(cur_gap), 64'(me.gap));
          end
        end
      end
      bclk_q = bclk;
      nf_q   = new_frame;
    end
  end

  initial begin
    int n, k, nf0;
    reset        = 1'b1;
    enable       = 1'b1;
    valid_sample = '0;
    repeat (3) @(negedge clk);
    chk_zero("rst_held");
`ifdef CODEC_FRAME_TX_COUNT_EN
    chk("rst_count", 64'(frame_count), 64'd0);
`endif

    @(posedge clk);
    #1 reset = 1'b0;
    frame(16'hA5C3, 0, 1'b1, n);
    chk("nf_after_reset", 64'(n), 64'd1);
    chk1("busy_run", busy, 1'b1);
    frame(16'hA5C3, 256, 1'b1, n);
    frame(16'h1234, 256, 1'b1, n);
    frame(16'hA5C3, 256, 1'b1, n);

    // sample changes mid-frame: right slot still carries the captured value
    frame(16'hA5C3, 256, 1'b1, n);
    repeat (79) @(posedge clk);
    #1 valid_sample = 16'h0001;
    frame(16'h0001, 256, 1'b1, n);

    // enable dropped at bit 10: frame runs to completion then idles
    frame(16'h8001, 256, 1'b1, n);
    repeat (39) @(posedge clk);
    #1 enable = 1'b0;
    k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drop_tail", 64'(k), 64'd217);
    chk1("idle_busy",  busy,  1'b0);
    chk1("idle_bclk",  bclk,  1'b0);
    chk1("idle_lrclk", lrclk, 1'b0);
    chk1("idle_sdata", sdata, 1'b0);
    nf0 = nf_seen;
    repeat (20) @(negedge clk);
    chk("idle_no_nf", 64'(nf_seen), 64'(nf0));

    @(posedge clk);
    #1 enable = 1'b1;
    frame(16'h7FFE, 0, 1'b1, n);
    chk("nf_after_enable", 64'(n), 64'd1);

    // reset pulse at bit 40 of the following frame
    frame(16'h1111, 256, 1'b0, n);
    repeat (159) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid");
`ifdef CODEC_FRAME_TX_COUNT_EN
    chk("rst_mid_count", 64'(frame_count), 64'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    frame(16'hC3A5, 0, 1'b1, n);
    chk("nf_after_rst_pulse", 64'(n), 64'd1);
`ifdef CODEC_FRAME_TX_COUNT_EN
    chk("count_after_rst", 64'(frame_count), 64'd1);
`endif
    frame(16'h5A5A, 256, 1'b1, n);
    enable = 1'b0;

    k = 0;
    while ((sb.size() != 0 || busy) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk1("end_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
